// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bin2bcd_pkg;

  // Converter control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // 10^d. This is the smallest magnitude that no longer fits in d BCD digits.
  // It is valid up to d = 19, which is well beyond any display this block drives.
  function automatic longint unsigned pow10(input int d);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < d; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Width of the bit counter. It must be able to hold the value p itself.
  function automatic int cnt_width(input int p);
    return (p < 1) ? 1 : $clog2(p + 1);
  endfunction

  // Width used for the overflow comparison. It is wide enough for both the
  // magnitude and 10^d, so the limit is never truncated.
  // ceil(3.33*d) is evaluated in integer arithmetic.
  function automatic int cmp_width(input int p, input int d);
    int c;
    c = ((333 * d) + 99) / 100 + 1;
    return (p > c) ? p : c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adjust.sv
// Double-dabble digit cell: adds 3 to a BCD digit of 5 or more before the next shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell is stateless.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // The 4-bit add wraps by design. Legal digits never exceed 9, so the largest result is 12.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one magnitude bit per clock, with sign/overflow flags.
// Latency: start at edge k gives done in the cycle after edge k+P; busy is high for exactly P cycles.
// Backpressure: start is ignored while busy; a start is accepted in the done cycle, giving one result per P+1 cycles.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int P = 4,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P-1:0]   mag,
  input  logic           sign_in,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           neg,
  output logic           ovf
);

  localparam int CNT_W = cnt_width(P);
  localparam int CMP_W = cmp_width(P, D);
  localparam logic [CMP_W-1:0] OVF_LIMIT = CMP_W'(pow10(D));

  state_t state, state_nxt;

  // Conversion scratch: the remaining binary bits and the partial BCD digits.
  logic [P-1:0]     shift_q;
  logic [4*D-1:0]   scratch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_pend_q;
  logic             ovf_pend_q;

  // Result registers seen by the display driver.
  logic [4*D-1:0]   bcd_q;
  logic             neg_q;
  logic             ovf_q;
  logic             done_q;

  // Per-cycle datapath values.
  logic [4*D-1:0]   adj;
  logic [4*D-1:0]   scratch_nxt;
  logic [P-1:0]     shift_nxt;
  logic [CMP_W-1:0] mag_ext;
  logic             load;
  logic             finish;

  // One adjust cell per digit. Each one is applied before the shift.
  genvar g;
  generate
    for (g = 0; g < D; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit    (scratch_q[4*g +: 4]),
        .adjusted (adj[4*g +: 4])
      );
    end
  endgenerate

  // Shift {adjusted scratch, shift} left by one. The top digit's MSB falls off,
  // which leaves the result equal to mag mod 10^D when the magnitude overflows.
  assign scratch_nxt = {adj[4*D-2:0], shift_q[P-1]};
  assign shift_nxt   = shift_q << 1;

  // Widen the magnitude so the 10^D limit compares without truncation.
  assign mag_ext = CMP_W'(mag);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, plus the load and finish strobes and busy.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scratch datapath: load on an accepted start, then shift once per CONV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else if (load) begin
      shift_q    <= mag;
      scratch_q  <= '0;
      cnt_q      <= CNT_W'(P);
      // A magnitude of zero is reported as positive whatever the sign flag says.
      neg_pend_q <= ~sign_in & (|mag);
      ovf_pend_q <= (mag_ext >= OVF_LIMIT);
    end else if (state == CONV) begin
      shift_q   <= shift_nxt;
      scratch_q <= scratch_nxt;
      cnt_q     <= cnt_q - CNT_W'(1);
    end
  end

  // Result registers: they update only on the final shift and hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        bcd_q <= scratch_nxt;
        neg_q <= neg_pend_q;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance 0: P=4, instance 1: P=8, instance 2: P=6. All use D=2.
  logic       start4 = 1'b0, start8 = 1'b0, start6 = 1'b0;
  logic [3:0] mag4 = '0;
  logic [7:0] mag8 = '0;
  logic [5:0] mag6 = '0;
  logic       sign4 = 1'b1, sign8 = 1'b1, sign6 = 1'b1;
  logic       busy4, busy8, busy6, done4, done8, done6;
  logic [7:0] bcd4, bcd8, bcd6;
  logic       neg4, neg8, neg6, ovf4, ovf8, ovf6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.P(4), .D(2)) u_p4 (
    .clk(clk), .rst(rst), .start(start4), .mag(mag4), .sign_in(sign4),
    .busy(busy4), .done(done4), .bcd(bcd4), .neg(neg4), .ovf(ovf4));
  bin2bcd_seq #(.P(8), .D(2)) u_p8 (
    .clk(clk), .rst(rst), .start(start8), .mag(mag8), .sign_in(sign8),
    .busy(busy8), .done(done8), .bcd(bcd8), .neg(neg8), .ovf(ovf8));
  bin2bcd_seq #(.P(6), .D(2)) u_p6 (
    .clk(clk), .rst(rst), .start(start6), .mag(mag6), .sign_in(sign6),
    .busy(busy6), .done(done6), .bcd(bcd6), .neg(neg6), .ovf(ovf6));

  // Reference model: the two decimal digits of (m mod 100), packed as BCD.
  function automatic logic [7:0] ref_bcd(input int m);
    int v;
    v = m % 100;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic ref_neg(input int m, input logic s);
    return (!s) && (m != 0);
  endfunction

  function automatic logic ref_ovf(input int m);
    return m >= 100;
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 8 : 6;
  endfunction

  task automatic drive(input int sel, input logic st, input int m, input logic s);
    case (sel)
      0: begin start4 = st; mag4 = 4'(m); sign4 = s; end
      1: begin start8 = st; mag8 = 8'(m); sign8 = s; end
      default: begin start6 = st; mag6 = 6'(m); sign6 = s; end
    endcase
  endtask

  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? busy4 : (sel == 1) ? busy8 : busy6;
  endfunction
  function automatic logic obs_done(input int sel);
    return (sel == 0) ? done4 : (sel == 1) ? done8 : done6;
  endfunction
  function automatic logic [7:0] obs_bcd(input int sel);
    return (sel == 0) ? bcd4 : (sel == 1) ? bcd8 : bcd6;
  endfunction
  function automatic logic obs_neg(input int sel);
    return (sel == 0) ? neg4 : (sel == 1) ? neg8 : neg6;
  endfunction
  function automatic logic obs_ovf(input int sel);
    return (sel == 0) ? ovf4 : (sel == 1) ? ovf8 : ovf6;
  endfunction

  // Pulse start for one cycle, then watch with a bounded window.
  // lat is the cycle index of the first done, counted from the accepting edge (-1 if none).
  // nbusy is the number of busy cycles before that done.
  // ndone is the number of done cycles up to two cycles after the first one.
  task automatic do_conv(input int sel, input int m, input logic s,
                         output int lat, output int nbusy, output int ndone,
                         output logic [7:0] b, output logic n, output logic o);
    lat = -1; nbusy = 0; ndone = 0; b = 'x; n = 1'bx; o = 1'bx;
    @(negedge clk); drive(sel, 1'b1, m, s);
    @(negedge clk); drive(sel, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (lat < 0 && obs_busy(sel)) nbusy++;
      if (obs_done(sel)) begin
        ndone++;
        if (lat < 0) begin
          lat = i; b = obs_bcd(sel); n = obs_neg(sel); o = obs_ovf(sel);
        end
      end
      if (lat >= 0 && i >= lat + 2) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, bcd4, neg4, ovf4} !== 12'h000) begin
      errors++; $display("FAIL reset_p4 got busy=%b done=%b bcd=%h neg=%b ovf=%b want all 0", busy4, done4, bcd4, neg4, ovf4);
    end
    checks++;
    if ({busy8, done8, bcd8, neg8, ovf8, busy6, done6, bcd6, neg6, ovf6} !== 24'h0) begin
      errors++; $display("FAIL reset_p8_p6 got bcd8=%h bcd6=%h busy8=%b busy6=%b want all 0", bcd8, bcd6, busy8, busy6);
    end
    rst = 1'b0;
  endtask

  task automatic check_conv(input string name, input int sel, input int m, input logic s);
    int lat, nb, nd; logic [7:0] b; logic n, o;
    do_conv(sel, m, s, lat, nb, nd, b, n, o);
    checks++;
    if (lat != width_of(sel) + 1 || nb != width_of(sel) || nd != 1) begin
      errors++; $display("FAIL %s_timing m=%0d got lat=%0d busy=%0d dones=%0d want lat=%0d busy=%0d dones=1",
                         name, m, lat, nb, nd, width_of(sel) + 1, width_of(sel));
    end
    checks++;
    if (b !== ref_bcd(m) || n !== ref_neg(m, s) || o !== ref_ovf(m)) begin
      errors++; $display("FAIL %s_value m=%0d s=%b got bcd=%h neg=%b ovf=%b want bcd=%h neg=%b ovf=%b",
                         name, m, s, b, n, o, ref_bcd(m), ref_neg(m, s), ref_ovf(m));
    end
  endtask

  task automatic test_basic;
    check_conv("p4_15", 0, 15, 1'b1);
    check_conv("p4_neg9", 0, 9, 1'b0);
    check_conv("p4_negzero", 0, 0, 1'b0);
  endtask

  task automatic test_overflow;
    check_conv("p8_200", 1, 200, 1'b1);
    check_conv("p8_99", 1, 99, 1'b1);
    check_conv("p8_255", 1, 255, 1'b0);
    check_conv("p8_100", 1, 100, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      check_conv("p8_rand", 1, int'($urandom_range(0, 255)), logic'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back;
    int first, second, nb;
    logic [7:0] b1, b2;
    first = -1; second = -1; nb = 0; b1 = 'x; b2 = 'x;
    @(negedge clk); drive(0, 1'b1, 12, 1'b1);
    @(negedge clk); drive(0, 1'b1, 3, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) @(negedge clk);
      if (first < 0 && busy4) nb++;
      if (done4) begin
        if (first < 0) begin first = i; b1 = bcd4; end
        else if (second < 0) begin second = i; b2 = bcd4; end
      end
      if (first >= 0 && i > first) drive(0, 1'b0, 0, 1'b1);
      else if (i >= 2) drive(0, 1'b1, 7, 1'b1);
      if (second >= 0) break;
    end
    drive(0, 1'b0, 0, 1'b1);
    checks++;
    if (first != 5 || nb != 4) begin
      errors++; $display("FAIL busy_ignore_timing got done_at=%0d busy=%0d want 5 and 4", first, nb);
    end
    checks++;
    if (b1 !== 8'h12) begin
      errors++; $display("FAIL busy_ignore_value got bcd=%h want 12", b1);
    end
    checks++;
    if (second < 0 || second - first != 5) begin
      errors++; $display("FAIL b2b_spacing got first=%0d second=%0d want spacing 5", first, second);
    end
    checks++;
    if (b2 !== 8'h07) begin
      errors++; $display("FAIL b2b_value got bcd=%h want 07", b2);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    nd = 0;
    @(negedge clk); drive(0, 1'b1, 9, 1'b0);
    @(negedge clk); drive(0, 1'b0, 0, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy4, done4, bcd4, neg4, ovf4} !== 12'h000) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b bcd=%h neg=%b ovf=%b want all 0", busy4, done4, bcd4, neg4, ovf4);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    checks++;
    if (nd != 0 || bcd4 !== 8'h00) begin
      errors++; $display("FAIL reset_mid_no_done got dones=%0d bcd=%h want 0 and 00", nd, bcd4);
    end
    check_conv("p4_after_reset", 0, 5, 1'b1);
  endtask

  task automatic test_sweep;
    for (int m = 0; m < 64; m++) begin
      for (int s = 0; s < 2; s++) begin
        check_conv("p6_sweep", 2, m, logic'(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Downstream stage of the P-bit magnitude/sign subtractor.
- Takes the subtractor's magnitude result and its sign flag, and converts the magnitude to D packed BCD digits with the iterative shift-add-3 (double-dabble) method, one bit per clock.
- Presents registered digits, a negative flag and an overflow flag to the display driver.
- Uses a start/busy/done handshake, so the subtractor output only needs to be stable in the start cycle.

Parameters:
- P, 4, width of the input magnitude in bits (P >= 1).
- D, 2, number of BCD output digits (D >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- mag  input  P  unsigned magnitude from the subtractor (RES).
- sign_in  input  1  subtractor sign, carry convention: 1 = non-negative, 0 = negative.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- bcd  output  4*D  packed BCD; digit 0 (units) in bits [3:0].
- neg  output  1  result is negative.
- ovf  output  1  magnitude did not fit in D digits.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (any state, including mid-conversion):
  - FSM goes to IDLE.
  - busy=0, done=0, bcd=0, neg=0, ovf=0.
  - Scratch registers and the bit counter are cleared.
  - No done pulse is produced for an aborted conversion.
- FSM states: IDLE, CONV.
- IDLE:
  - If start=1 at edge k: load shift register <= mag, clear the BCD scratch.
  - Latch neg_pending = (~sign_in) & (mag != 0).
  - Latch ovf_pending = (mag >= 10^D), computed at elaboration-sized width.
  - Set counter <= P, busy <= 1, go to CONV.
- CONV, each edge:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry out).
  - Then {scratch, shift} shifts left one bit; the MSB of the top digit is discarded.
  - Counter decrements.
- On the edge where counter goes 1 -> 0 (edge k+P):
  - bcd <= final scratch value (post-shift).
  - neg <= neg_pending, ovf <= ovf_pending.
  - done <= 1, busy <= 0, go to IDLE.
- Latency:
  - busy is high for exactly P cycles.
  - done is high for the single cycle following edge k+P.
  - Result is valid from that cycle and holds until the next completion or reset.
- start while busy=1: ignored. There is no queuing.
- start in the cycle done=1: accepted, since the FSM is in IDLE; back-to-back conversions sustain one result per P+1 cycles.
- mag and sign_in are don't-care outside the start cycle in IDLE.
- Overflow: bcd holds (mag mod 10^D) correctly, because digits below the discarded top bits are unaffected.
- Negative zero (sign_in=0, mag=0) reports neg=0.
- Width rules:
  - Counter width is clog2(P+1).
  - The 10^D comparison is done on max(P, ceil(3.33*D)+1) bits so that no truncation occurs.

Decomposition:
- Package bin2bcd_pkg contains:
  - state enum (IDLE, CONV);
  - localparam function pow10(D) for the overflow limit;
  - function clog2-based counter width helper.
- Sub-module bcd_digit_adjust: combinational 4-bit cell, out = (in >= 5) ? in + 3 : in. It is instantiated D times in a generate loop.
- The FSM, counter and shift datapath stay in bin2bcd_seq.

Test Plan:
- P=4, D=2, mag=15, sign_in=1, start pulse -> busy high 4 cycles; done in cycle 5; bcd=8'h15, neg=0, ovf=0.
- P=4, D=2, mag=9, sign_in=0 -> bcd=8'h09, neg=1, ovf=0. Then mag=0, sign_in=0 -> bcd=8'h00, neg=0.
- P=8, D=2, mag=200 -> ovf=1, bcd=8'h00. mag=99 -> ovf=0, bcd=8'h99. mag=255 -> ovf=1, bcd=8'h55.
- Busy handling: start re-asserted during busy with mag=3 is ignored, and the original result (mag=12 -> 8'h12) completes. Start held high through the done cycle with mag=7 -> second done exactly P+1 cycles after the first, bcd=8'h07.
- Reset mid-conversion: rst=1 two cycles after start -> next cycle busy=0, bcd=0, no done pulse; a fresh start afterwards converts mag=5 -> 8'h05.
- Exhaustive sweep: P=6, D=2, all mag 0..63 × sign_in -> bcd matches the decimal reference model, neg and ovf are correct, and there is exactly one done per start.
